mbssoc_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port SoC RAM between the core's instruction-fetch port (read-only) and data port (read/write). Each port uses a valid/ready request channel and a one-cycle response pulse. The arbiter sequences the RAM's registered-address read timing, drives the shared bidirectional data bus only during writes, and rejects misaligned accesses. It sits between the core and the RAM.

---
 rtl/mbssoc_mem_arbiter_if.sv | 32 +++
 rtl/mbssoc_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mbssoc_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mbssoc_mem_arbiter_if.sv
// rtl/mbssoc_mem_arbiter_if.sv - core-side request/response bundle for the fetch and data ports
interface mbssoc_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_rsp_valid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;
  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_rsp_valid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata,
    input  if_req_ready, if_rsp_valid, if_rdata, if_err,
    input  d_req_ready, d_rsp_valid, d_rdata, d_err
  );

  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata,
    output if_req_ready, if_rsp_valid, if_rdata, if_err,
    output d_req_ready, d_rsp_valid, d_rdata, d_err
  );
endinterface

// File: rtl/mbssoc_mem_arbiter.sv
// rtl/mbssoc_mem_arbiter.sv - round-robin fetch/data arbiter in front of the single-port SoC RAM
module mbssoc_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mbssoc_mem_arbiter_if.slave   core,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic                  ram_wr_invalid,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  state_t                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_re_q;
  logic                  ram_we_q;
  logic                  ram_wr_invalid_q;
  logic                  if_rsp_valid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic                  if_err_q;
  logic                  d_rsp_valid_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  d_err_q;

  logic                  if_sel_d;
  logic                  d_sel_d;
  logic                  idle_d;
  logic                  accept_d;
  logic [ADDR_WIDTH-1:0] req_addr_d;
  logic                  req_we_d;
  logic                  misaligned_d;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    if_sel_d     = core.if_req_valid && (!core.d_req_valid || (last_grant_q == GRANT_D));
    d_sel_d      = core.d_req_valid && !if_sel_d;
    idle_d       = (state_q == IDLE) && !rst;
    accept_d     = idle_d && (if_sel_d || d_sel_d);
    req_addr_d   = d_sel_d ? core.d_addr : core.if_addr;
    req_we_d     = d_sel_d && core.d_we;
    misaligned_d = (req_addr_d[1:0] != 2'b00);
  end

  assign core.if_req_ready = idle_d && if_sel_d;
  assign core.d_req_ready  = idle_d && d_sel_d;
  assign core.if_rsp_valid = if_rsp_valid_q;
  assign core.if_rdata     = if_rdata_q;
  assign core.if_err       = if_err_q;
  assign core.d_rsp_valid  = d_rsp_valid_q;
  assign core.d_rdata      = d_rdata_q;
  assign core.d_err        = d_err_q;

  assign ram_addr       = ram_addr_q;
  assign ram_re         = ram_re_q;
  assign ram_we         = ram_we_q;
  assign ram_wr_invalid = ram_wr_invalid_q;
  assign busy           = (state_q != IDLE);
  assign ram_data       = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      grant_q          <= GRANT_IF;
      last_grant_q     <= GRANT_D;
      wdata_q          <= '0;
      drive_q          <= 1'b0;
      ram_addr_q       <= '0;
      ram_re_q         <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_wr_invalid_q <= 1'b0;
      if_rsp_valid_q   <= 1'b0;
      if_rdata_q       <= '0;
      if_err_q         <= 1'b0;
      d_rsp_valid_q    <= 1'b0;
      d_rdata_q        <= '0;
      d_err_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ram_wr_invalid_q <= 1'b1;
          if (accept_d) begin
            grant_q      <= d_sel_d;
            last_grant_q <= d_sel_d;
            wdata_q      <= core.d_wdata;
            if (misaligned_d) begin
              // Rejected without touching the RAM; error reported next cycle.
              state_q <= RESP;
              if (d_sel_d) begin
                d_rsp_valid_q <= 1'b1;
                d_err_q       <= 1'b1;
                d_rdata_q     <= '0;
              end else begin
                if_rsp_valid_q <= 1'b1;
                if_err_q       <= 1'b1;
                if_rdata_q     <= '0;
              end
            end else if (req_we_d) begin
              state_q          <= WR;
              ram_addr_q       <= req_addr_d;
              ram_we_q         <= 1'b1;
              ram_wr_invalid_q <= 1'b0;
              drive_q          <= 1'b1;
            end else begin
              state_q    <= RD_ADDR;
              ram_addr_q <= req_addr_d;
              ram_re_q   <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          state_q  <= RESP;
          ram_re_q <= 1'b0;
          if (grant_q == GRANT_D) begin
            d_rsp_valid_q <= 1'b1;
            d_rdata_q     <= ram_data;
            d_err_q       <= 1'b0;
          end else begin
            if_rsp_valid_q <= 1'b1;
            if_rdata_q     <= ram_data;
            if_err_q       <= 1'b0;
          end
        end
        WR: begin
          state_q          <= RESP;
          ram_we_q         <= 1'b0;
          ram_wr_invalid_q <= 1'b1;
          drive_q          <= 1'b0;
          d_rsp_valid_q    <= 1'b1;
          d_rdata_q        <= '0;
          d_err_q          <= 1'b0;
        end
        RESP: begin
          state_q        <= IDLE;
          if_rsp_valid_q <= 1'b0;
          d_rsp_valid_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbssoc_mem_arbiter.sv
// tb/tb_mbssoc_mem_arbiter.sv - directed vector and corner-case bench for mbssoc_mem_arbiter
module tb_mbssoc_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_wait;
    int          re_cyc;
    int          we_cyc;
    int          nwi_cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mbssoc_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  wire  [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_re, ram_we, ram_wr_invalid, busy;

  mbssoc_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .core(bus),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wr_invalid(ram_wr_invalid), .ram_data(ram_data), .busy(busy)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h0BADF00D;
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // RAM model: registered read address, write on ram_we unless suppressed.
  logic [31:0] mem [0:63];
  logic [5:0]  rd_idx;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      rd_idx <= '0;
    end else begin
      if (ram_re) rd_idx <= ram_addr[7:2];
      if (ram_we && !ram_wr_invalid) mem[ram_addr[7:2]] <= ram_data;
    end
  end
  assign ram_data = ram_re ? mem[rd_idx] : {DW{1'bz}};

  int checks = 0;
  int failures = 0;
  logic [31:0] shadow [0:63];
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic inv_check();
    checks++;
    if ((ram_re && dut.drive_q) || (ram_re && ram_we) || (ram_we && ram_wr_invalid) ||
        (bus.if_rsp_valid && bus.d_rsp_valid) || (bus.if_req_ready && bus.d_req_ready)) begin
      failures++;
      $display("FAIL bus_invariant re=%0b drv=%0b we=%0b wi=%0b ifrsp=%0b drsp=%0b ifrdy=%0b drdy=%0b required=no_overlap",
               ram_re, dut.drive_q, ram_we, ram_wr_invalid, bus.if_rsp_valid, bus.d_rsp_valid,
               bus.if_req_ready, bus.d_req_ready);
    end
  endtask

  task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output res_t r);
    bit rdy;
    bit got;
    r = '{rdata: '0, err: 1'b0, lat: 0, acc_wait: 0, re_cyc: 0, we_cyc: 0, nwi_cyc: 0};
    if (is_d) begin
      bus.d_req_valid = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_addr = addr;
    end
    #1;
    rdy = is_d ? bus.d_req_ready : bus.if_req_ready;
    while (!rdy && r.acc_wait < 20) begin
      inv_check();
      @(negedge clk); #1;
      r.acc_wait++;
      rdy = is_d ? bus.d_req_ready : bus.if_req_ready;
    end
    inv_check();
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL accept_timeout port=%0d actual=not_ready required=ready", is_d);
      bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
      r.lat = -1;
      return;
    end
    @(negedge clk);
    bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
    #1;
    r.lat = 1;
    got = 1'b0;
    while (!got && r.lat <= 10) begin
      inv_check();
      if (ram_re) begin r.re_cyc++; chk("rd_ram_addr", ram_addr, addr); end
      if (ram_we) begin
        r.we_cyc++;
        chk("wr_ram_addr", ram_addr, addr);
        chk("wr_ram_data", ram_data, wdata);
      end
      if (!ram_wr_invalid) r.nwi_cyc++;
      chk("wrong_port_rsp", 32'(is_d ? bus.if_rsp_valid : bus.d_rsp_valid), 32'd0);
      got = is_d ? bus.d_rsp_valid : bus.if_rsp_valid;
      if (!got) begin @(negedge clk); #1; r.lat++; end
    end
    r.rdata = is_d ? bus.d_rdata : bus.if_rdata;
    r.err   = is_d ? bus.d_err : bus.if_err;
  endtask

  initial begin
    res_t r;
    bit   order [4];
    int   n, cyc;

    vecs[0] = '{1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 2, 0};
    vecs[1] = '{1, 1, 32'h20, 32'h12345678, 32'h0,        0, 2, 0, 1};
    vecs[2] = '{0, 0, 32'h20, 32'h0,        32'h12345678, 0, 3, 2, 0};
    vecs[3] = '{1, 1, 32'h22, 32'hFFFF0000, 32'h0,        1, 1, 0, 0};
    vecs[4] = '{0, 0, 32'h03, 32'h0,        32'h0,        1, 1, 0, 0};
    vecs[5] = '{1, 0, 32'h11, 32'h0,        32'h0,        1, 1, 0, 0};
    vecs[6] = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 2, 0};
    vecs[7] = '{1, 1, 32'h3C, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1};
    vecs[8] = '{1, 0, 32'h3C, 32'h0,        32'hCAFEF00D, 0, 3, 2, 0};

    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_if_rsp", 32'(bus.if_rsp_valid), 32'd0);
    chk("rst_d_rsp", 32'(bus.d_rsp_valid), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_err", 32'(bus.d_err), 32'd0);
    chk("rst_bus_drive", 32'(dut.drive_q), 32'd0);

    // Reset arriving mid-read drops the transaction.
    @(negedge clk);
    rst = 1'b0;
    bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    #1;
    chk("mid_d_ready", 32'(bus.d_req_ready), 32'd1);
    @(negedge clk);
    bus.d_req_valid = 1'b0;
    #1;
    chk("mid_rdaddr_re", 32'(ram_re), 32'd1);
    chk("mid_rdaddr_addr", ram_addr, 32'h10);
    @(negedge clk); #1;
    chk("mid_rddata_re", 32'(ram_re), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_re", 32'(ram_re), 32'd0);
    chk("mid_rst_drive", 32'(dut.drive_q), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_rsp", 32'(bus.d_rsp_valid | bus.if_rsp_valid), 32'd0);
      @(negedge clk); #1;
    end
    rst = 1'b0;
    issue(0, 0, 32'h0, 32'h0, r);
    chk("post_rst_acc_wait", 32'(r.acc_wait), 32'd0);
    chk("post_rst_lat", 32'(r.lat), 32'd3);
    chk("post_rst_rdata", r.rdata, 32'h0BADF00D);

    // Both ports requesting continuously from reset.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h0;
    bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    #1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      inv_check();
      if (bus.if_req_ready) begin order[n] = 1'b0; n++; end
      else if (bus.d_req_ready) begin order[n] = 1'b1; n++; end
      @(negedge clk); #1;
      cyc++;
    end
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    chk("rr_grant_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
    cyc = 0;
    while (busy && cyc < 20) begin inv_check(); @(negedge clk); #1; cyc++; end
    chk("rr_drain_busy", 32'(busy), 32'd0);
    chk("rr_if_rdata", bus.if_rdata, 32'h0BADF00D);
    chk("rr_d_rdata", bus.d_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, r);
      chk($sformatf("vec%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(r.err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(r.lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_re_cycles", i), 32'(r.re_cyc), 32'(vecs[i].exp_re));
      chk($sformatf("vec%0d_we_cycles", i), 32'(r.we_cyc), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_wr_enabled_cycles", i), 32'(r.nwi_cyc), 32'(vecs[i].exp_we));
      if (vecs[i].we && vecs[i].addr[1:0] == 2'b00) shadow[vecs[i].addr[7:2]] = vecs[i].wdata;
    end
    chk("word8_after_misaligned", mem[8], 32'h12345678);

    for (int k = 0; k < 200; k++) begin
      bit          is_d, we;
      int          idx;
      logic [31:0] wd;
      is_d = 1'($urandom_range(0, 1));
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      idx  = int'($urandom_range(0, 63));
      wd   = $urandom;
      issue(is_d, we, 32'(idx * 4), wd, r);
      if (we) begin
        shadow[idx] = wd;
        chk($sformatf("rnd%0d_wr_lat", k), 32'(r.lat), 32'd2);
      end else begin
        chk($sformatf("rnd%0d_rd_lat", k), 32'(r.lat), 32'd3);
        chk($sformatf("rnd%0d_rdata", k), r.rdata, shadow[idx]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
